// File: rtl/watches_pkg.sv
// Shared types and width helpers for the watches set-mode sequencer.
package watches_pkg;

  typedef enum logic [1:0] {
    SM_RUN     = 2'd0,
    SM_SET_HR  = 2'd1,
    SM_SET_MIN = 2'd2
  } set_mode_t;

  // Bits needed to hold every value 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

  localparam int unsigned DEF_CLK_HZ        = 50_000_000;
  localparam int unsigned DEF_TIMEOUT_S     = 10;
  localparam int unsigned DEF_REPEAT_DELAY  = 25_000_000;
  localparam int unsigned DEF_REPEAT_PERIOD = 5_000_000;

  localparam int unsigned DEF_DIV_W = cnt_width(DEF_CLK_HZ - 1);
  localparam int unsigned DEF_TO_W  = cnt_width(DEF_TIMEOUT_S);
  localparam int unsigned DEF_REP_W = cnt_width(DEF_REPEAT_DELAY);

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchronizer plus edge register for one debounced button level.
// rise_o is high for one cycle, two edges after the button is first sampled high.
module btn_sync_edge (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic btn_i,
  output logic rise_o,
  output logic level_o
);

  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= btn_i;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise_o  = s2_q & ~s3_q;
  assign level_o = s2_q;

endmodule

// File: rtl/watches_set_ctrl.sv
// 1 Hz tact generator and RUN/SET_HR/SET_MIN time-set sequencer for the watches counters.
// Button actions become visible three clock edges after the button is first sampled high.
module watches_set_ctrl
  import watches_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DEF_CLK_HZ,
  parameter int unsigned TIMEOUT_S     = DEF_TIMEOUT_S,
  parameter int unsigned REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       mode_btn_i,
  input  logic       up_btn_i,
  output logic       last_tact_o,
  output logic       user_time_val_o,
  output logic       user_hour_up_o,
  output logic       user_min_up_o,
  output logic       sec_clr_o,
  output logic [1:0] set_mode_o
);

  localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned DIV_W   = cnt_width(CLK_HZ - 1);
  localparam int unsigned TO_W    = cnt_width(TIMEOUT_S);
  localparam int unsigned REP_W   = cnt_width(REP_MAX);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_S - 1);
  localparam logic [REP_W-1:0] REP_DLY  = REP_W'(REPEAT_DELAY);
  localparam logic [REP_W-1:0] REP_PER  = REP_W'(REPEAT_PERIOD);

  logic mode_rise, mode_lvl_unused, up_rise, up_lvl;

  btn_sync_edge u_mode_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_i   (mode_btn_i),
    .rise_o  (mode_rise),
    .level_o (mode_lvl_unused)
  );

  btn_sync_edge u_up_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .btn_i   (up_btn_i),
    .rise_o  (up_rise),
    .level_o (up_lvl)
  );

  set_mode_t        state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_act_q, rep_act_d;
  logic             rep_phase_q, rep_phase_d;
  logic             tv_q, tv_d;
  logic             tact_q, tact_d;
  logic             hour_up_q, hour_up_d;
  logic             min_up_q, min_up_d;
  logic             sec_clr_q, sec_clr_d;
  logic             fire;

  logic in_set, wrap, timeout, up_ok;
  assign in_set  = (state_q != SM_RUN);
  assign wrap    = (cnt_q == DIV_LAST);
  assign timeout = in_set && wrap && (to_cnt_q == TO_LAST);
  assign up_ok   = in_set && up_rise && !mode_rise;

  always_comb begin
    state_d     = state_q;
    cnt_d       = wrap ? '0 : cnt_q + 1'b1;
    to_cnt_d    = to_cnt_q;
    rep_cnt_d   = rep_cnt_q;
    rep_act_d   = rep_act_q;
    rep_phase_d = rep_phase_q;
    tact_d      = 1'b0;
    hour_up_d   = 1'b0;
    min_up_d    = 1'b0;
    sec_clr_d   = 1'b0;
    fire        = 1'b0;

    // Mode beats everything; an up rise in the same cycle as a timeout keeps the state.
    if (mode_rise) begin
      case (state_q)
        SM_RUN:    state_d = SM_SET_HR;
        SM_SET_HR: state_d = SM_SET_MIN;
        default:   state_d = SM_RUN;
      endcase
    end else if (timeout && !up_rise) begin
      state_d = SM_RUN;
    end

    if (!in_set || (state_d != state_q) || mode_rise || up_rise) begin
      to_cnt_d = '0;
    end else if (wrap) begin
      to_cnt_d = to_cnt_q + 1'b1;
    end

    // Restart the second from zero when leaving set mode.
    if (in_set && (state_d == SM_RUN)) begin
      cnt_d     = '0;
      sec_clr_d = 1'b1;
    end
    tact_d = wrap && (state_q == SM_RUN) && (state_d == SM_RUN);

    // Repeat dies on release or any state change and only re-arms on a fresh rise.
    if ((state_d != state_q) || mode_rise || !up_lvl) begin
      rep_act_d   = 1'b0;
      rep_phase_d = 1'b0;
      rep_cnt_d   = '0;
    end else if (up_ok) begin
      fire        = 1'b1;
      rep_act_d   = 1'b1;
      rep_phase_d = 1'b0;
      rep_cnt_d   = REP_W'(1);
    end else if (rep_act_q) begin
      if (rep_cnt_q == (rep_phase_q ? REP_PER : REP_DLY)) begin
        fire        = 1'b1;
        rep_phase_d = 1'b1;
        rep_cnt_d   = REP_W'(1);
      end else begin
        rep_cnt_d = rep_cnt_q + 1'b1;
      end
    end

    hour_up_d = fire && (state_q == SM_SET_HR);
    min_up_d  = fire && (state_q == SM_SET_MIN);
    tv_d      = (state_d != SM_RUN);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q     <= SM_RUN;
      cnt_q       <= '0;
      to_cnt_q    <= '0;
      rep_cnt_q   <= '0;
      rep_act_q   <= 1'b0;
      rep_phase_q <= 1'b0;
      tv_q        <= 1'b0;
      tact_q      <= 1'b0;
      hour_up_q   <= 1'b0;
      min_up_q    <= 1'b0;
      sec_clr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      to_cnt_q    <= to_cnt_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_act_q   <= rep_act_d;
      rep_phase_q <= rep_phase_d;
      tv_q        <= tv_d;
      tact_q      <= tact_d;
      hour_up_q   <= hour_up_d;
      min_up_q    <= min_up_d;
      sec_clr_q   <= sec_clr_d;
    end
  end

  assign last_tact_o     = tact_q;
  assign user_time_val_o = tv_q;
  assign user_hour_up_o  = hour_up_q;
  assign user_min_up_o   = min_up_q;
  assign sec_clr_o       = sec_clr_q;
  assign set_mode_o      = state_q;

endmodule

// File: tb/tb_watches_set_ctrl.sv
// Directed bench for watches_set_ctrl with CLK_HZ=10, TIMEOUT_S=3, REPEAT_DELAY=8, REPEAT_PERIOD=4.
module tb_watches_set_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_n_i = 1'b0;
  logic       mode_btn_i = 1'b0;
  logic       up_btn_i = 1'b0;
  logic       last_tact_o, user_time_val_o, user_hour_up_o, user_min_up_o, sec_clr_o;
  logic [1:0] set_mode_o;

  watches_set_ctrl #(
    .CLK_HZ        (10),
    .TIMEOUT_S     (3),
    .REPEAT_DELAY  (8),
    .REPEAT_PERIOD (4)
  ) dut (
    .clk_i           (clk_i),
    .rst_n_i         (rst_n_i),
    .mode_btn_i      (mode_btn_i),
    .up_btn_i        (up_btn_i),
    .last_tact_o     (last_tact_o),
    .user_time_val_o (user_time_val_o),
    .user_hour_up_o  (user_hour_up_o),
    .user_min_up_o   (user_min_up_o),
    .sec_clr_o       (sec_clr_o),
    .set_mode_o      (set_mode_o)
  );

  always #5 clk_i = ~clk_i;

  // Output vector layout: {tact, time_val, hour_up, min_up, sec_clr, set_mode[1:0]}
  localparam logic [6:0] M_ALL  = 7'b1111111;
  localparam logic [6:0] M_MODE = 7'b0000011;
  localparam logic [6:0] M_UP   = 7'b0011000;
  localparam logic [6:0] M_TV   = 7'b0100000;

  int n_cmp = 0;
  int n_err = 0;
  int k = 0;
  int rel = 0;

  function automatic logic [6:0] ev(input logic tact, input logic tv, input logic hu,
                                    input logic mu, input logic sc, input logic [1:0] md);
    return {tact, tv, hu, mu, sc, md};
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
    k++;
  endtask

  task automatic chk(input string tag, input logic [6:0] mask, input logic [6:0] exp);
    logic [6:0] obs;
    obs = {last_tact_o, user_time_val_o, user_hour_up_o, user_min_up_o, sec_clr_o, set_mode_o} & mask;
    n_cmp++;
    assert (obs === (exp & mask)) else begin
      n_err++;
      $error("FAIL %s k=%0d observed=%b required=%b", tag, k, obs, exp & mask);
    end
  endtask

  task automatic press_mode(input logic [1:0] from_m, input logic [1:0] to_m);
    mode_btn_i = 1'b1;
    tick();
    tick();
    mode_btn_i = 1'b0;
    chk("mode_before", M_MODE, ev(0, 0, 0, 0, 0, from_m));
    tick();
    chk("mode_after", M_MODE | M_TV, ev(0, to_m != 2'd0, 0, 0, 0, to_m));
  endtask

  task automatic press_up(input logic hu, input logic mu);
    up_btn_i = 1'b1;
    tick();
    tick();
    up_btn_i = 1'b0;
    chk("up_before", M_UP, ev(0, 0, 0, 0, 0, 2'd0));
    tick();
    chk("up_pulse", M_UP, ev(0, 0, hu, mu, 0, 2'd0));
    tick();
    chk("up_gap", M_UP, ev(0, 0, 0, 0, 0, 2'd0));
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset and free-running divider
    tick(); tick(); tick();
    chk("reset_state", M_ALL, ev(0, 0, 0, 0, 0, 2'd0));
    rst_n_i = 1'b1;
    k = 0;
    repeat (35) begin
      tick();
      chk("idle_tact", M_ALL, ev(k % 10 == 0, 0, 0, 0, 0, 2'd0));
    end

    // Mode cycling, no tact in set mode, exit realigns the second
    press_mode(2'd0, 2'd1);
    repeat (5) begin
      tick();
      chk("set_no_tact", M_ALL, ev(0, 1, 0, 0, 0, 2'd1));
    end
    press_mode(2'd1, 2'd2);
    press_mode(2'd2, 2'd0);
    chk("exit_clr", M_ALL, ev(0, 0, 0, 0, 1, 2'd0));
    repeat (11) begin
      tick();
      chk("exit_tact", M_ALL, ev(k == 59, 0, 0, 0, 0, 2'd0));
    end

    // Single up presses in each set state
    press_mode(2'd0, 2'd1);
    repeat (3) press_up(1'b1, 1'b0);
    press_mode(2'd1, 2'd2);
    repeat (3) press_up(1'b0, 1'b1);

    // Held up in SET_MIN: first pulse, then after 8, then every 4
    up_btn_i = 1'b1;
    repeat (25) begin
      tick();
      if (k == 110) up_btn_i = 1'b0;
      chk("repeat", M_UP, ev(0, 0, 0, (k == 93) || (k == 101) || (k == 105) || (k == 109), 0, 2'd0));
    end

    // Inactivity timeout from SET_MIN
    while (k < 118) tick();
    chk("to_hold_min", M_MODE, ev(0, 0, 0, 0, 0, 2'd2));
    tick();
    chk("to_exit_min", M_ALL, ev(0, 0, 0, 0, 1, 2'd0));
    repeat (10) begin
      tick();
      chk("to_tact_min", M_ALL, ev(k == 129, 0, 0, 0, 0, 2'd0));
    end

    // Up rise on the timeout wrap keeps SET_HR and restarts the count
    press_mode(2'd0, 2'd1);
    while (k < 156) tick();
    chk("to_pre_race", M_MODE, ev(0, 0, 0, 0, 0, 2'd1));
    press_up(1'b1, 1'b0);
    chk("to_race_stay", M_ALL, ev(0, 1, 0, 0, 0, 2'd1));
    while (k < 188) tick();
    chk("to_restart_hold", M_ALL, ev(0, 1, 0, 0, 0, 2'd1));
    tick();
    chk("to_exit_hr", M_ALL, ev(0, 0, 0, 0, 1, 2'd0));
    repeat (10) begin
      tick();
      chk("to_tact_hr", M_ALL, ev(k == 199, 0, 0, 0, 0, 2'd0));
    end

    // Mode and up rising together: mode wins, held up never repeats
    press_mode(2'd0, 2'd1);
    mode_btn_i = 1'b1;
    up_btn_i   = 1'b1;
    tick();
    tick();
    mode_btn_i = 1'b0;
    tick();
    chk("mode_wins", M_ALL, ev(0, 1, 0, 0, 0, 2'd2));
    repeat (15) begin
      tick();
      if (k == 217) up_btn_i = 1'b0;
      chk("no_repeat", M_UP | M_MODE, ev(0, 0, 0, 0, 0, 2'd2));
    end

    // Reset while up is held in SET_MIN
    up_btn_i = 1'b1;
    tick(); tick(); tick();
    chk("held_pulse", M_UP, ev(0, 0, 0, 1, 0, 2'd0));
    tick(); tick(); tick();
    chk("pre_reset", M_ALL, ev(0, 1, 0, 0, 0, 2'd2));
    rst_n_i = 1'b0;
    #1;
    chk("async_reset", M_ALL, ev(0, 0, 0, 0, 0, 2'd0));
    tick();
    tick();
    chk("in_reset", M_ALL, ev(0, 0, 0, 0, 0, 2'd0));
    rst_n_i = 1'b1;
    rel = k;
    repeat (12) begin
      tick();
      if (k - rel == 5) up_btn_i = 1'b0;
      chk("post_reset", M_ALL, ev((k - rel) == 10, 0, 0, 0, 0, 2'd0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
